// File: rtl/match_control_if.sv
// Handshake/status bundle between the game controller and its environment.
// The master side (game environment) drives frame, button and rally-result
// pulses; the slave side (match_control) returns serve control, scores and
// screen selection.
interface match_control_if;
  logic       end_of_frame;
  logic       start_btn;
  logic       quit_btn;
  logic       mode_multi;
  logic       ball_ready;
  logic       point_p1;
  logic       point_p2;
  logic       serve;
  logic       serve_dir;
  logic [3:0] points_player_1;
  logic [3:0] points_player_2;
  logic       screen_idle;
  logic       screen_multi;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output end_of_frame, start_btn, quit_btn, mode_multi, ball_ready,
    output point_p1, point_p2,
    input  serve, serve_dir, points_player_1, points_player_2,
    input  screen_idle, screen_multi, game_over, winner
  );

  modport slave (
    input  end_of_frame, start_btn, quit_btn, mode_multi, ball_ready,
    input  point_p1, point_p2,
    output serve, serve_dir, points_player_1, points_player_2,
    output screen_idle, screen_multi, game_over, winner
  );
endinterface

// File: rtl/match_control.sv
// Match sequencing for a two-paddle ball game: waits for start, times the
// automatic serve in video frames, scores rallies, detects the winner and
// returns to the idle screen. Every output is a register updated together
// with the state so that no output ever glitches on a combinational path.
module match_control #(
  parameter int WIN_SCORE          = 10,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic         clk65MHz,
  input  logic         rst_n,
  match_control_if.slave bus
);

  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY = 8'(SERVE_DELAY_FRAMES);

  localparam logic [1:0] SCORER_NONE = 2'b00;
  localparam logic [1:0] SCORER_P1   = 2'b01;
  localparam logic [1:0] SCORER_P2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SERVE = 3'd1,
    RALLY      = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] frame_cnt;
  // Who took the last rally; SCORER_NONE marks a replay (both pulses at once)
  // so the next serve keeps its direction.
  logic [1:0] last_scorer;

  // Score increment that can never pass the winning total.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    logic [3:0] result;
    if (value >= WIN) begin
      result = value;
    end else begin
      result = value + 4'd1;
    end
    return result;
  endfunction

  // Match FSM with all outputs registered alongside the state.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      frame_cnt           <= 8'd0;
      last_scorer         <= SCORER_NONE;
      bus.serve           <= 1'b0;
      bus.serve_dir       <= 1'b1;
      bus.points_player_1 <= 4'd0;
      bus.points_player_2 <= 4'd0;
      bus.winner          <= 2'b00;
      bus.game_over       <= 1'b0;
      bus.screen_idle     <= 1'b1;
      bus.screen_multi    <= 1'b0;
    end else begin
      // serve is a single-cycle pulse; only the serving transition sets it
      bus.serve <= 1'b0;

      if (bus.quit_btn) begin
        // Abandon the match from anywhere; scores stay visible
        state           <= IDLE;
        bus.winner      <= 2'b00;
        bus.game_over   <= 1'b0;
        bus.screen_idle <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_btn) begin
              state               <= WAIT_SERVE;
              frame_cnt           <= 8'd0;
              last_scorer         <= SCORER_NONE;
              bus.points_player_1 <= 4'd0;
              bus.points_player_2 <= 4'd0;
              bus.winner          <= 2'b00;
              bus.serve_dir       <= 1'b1;
              bus.screen_multi    <= bus.mode_multi;
              bus.screen_idle     <= 1'b0;
              bus.game_over       <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end

          WAIT_SERVE: begin
            // Serve needs the ball parked; start forces an early serve
            if (bus.ball_ready && ((frame_cnt == DELAY) || bus.start_btn)) begin
              bus.serve <= 1'b1;
              state     <= RALLY;
            end else if (bus.end_of_frame && (frame_cnt < DELAY)) begin
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              state <= WAIT_SERVE;
            end
          end

          RALLY: begin
            if (bus.point_p1 && bus.point_p2) begin
              last_scorer <= SCORER_NONE;
              state       <= POINT;
            end else if (bus.point_p1) begin
              bus.points_player_1 <= sat_inc(bus.points_player_1);
              last_scorer         <= SCORER_P1;
              state               <= POINT;
            end else if (bus.point_p2) begin
              bus.points_player_2 <= sat_inc(bus.points_player_2);
              last_scorer         <= SCORER_P2;
              state               <= POINT;
            end else begin
              state <= RALLY;
            end
          end

          POINT: begin
            if (bus.points_player_1 == WIN) begin
              state         <= GAME_OVER;
              bus.game_over <= 1'b1;
              bus.winner    <= 2'b01;
            end else if (bus.points_player_2 == WIN) begin
              state         <= GAME_OVER;
              bus.game_over <= 1'b1;
              bus.winner    <= 2'b10;
            end else begin
              state     <= WAIT_SERVE;
              frame_cnt <= 8'd0;
              // Ball goes toward the player who conceded the point
              case (last_scorer)
                SCORER_P1: bus.serve_dir <= 1'b0;
                SCORER_P2: bus.serve_dir <= 1'b1;
                default:   bus.serve_dir <= bus.serve_dir;
              endcase
            end
          end

          GAME_OVER: begin
            if (bus.start_btn) begin
              state           <= IDLE;
              bus.game_over   <= 1'b0;
              bus.screen_idle <= 1'b1;
            end else begin
              state <= GAME_OVER;
            end
          end

          default: begin
            state           <= IDLE;
            bus.game_over   <= 1'b0;
            bus.screen_idle <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
